// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader filling instruction memory and gating core start
module imem_loader #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        prog_en,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        start,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN0 = 3'd1;
    localparam logic [2:0] LEN1 = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;
    localparam logic [2:0] RUN  = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    logic [2:0]  state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic        rx_ready_q, rx_ready_d;
    logic        prog_en_q, prog_en_d;
    logic [31:0] prog_addr_q, prog_addr_d;
    logic [31:0] prog_data_q, prog_data_d;
    logic        start_q, start_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;
    logic [15:0] words_loaded_q, words_loaded_d;

    logic        accept;
    logic        is_sync;
    logic [15:0] n_full;

    assign accept  = rx_valid && rx_ready_q;
    assign is_sync = (rx_data == SYNC_BYTE);
    assign n_full  = {rx_data, n_q[7:0]};

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        word_idx_d     = word_idx_q;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        csum_d         = csum_q;
        rx_ready_d     = 1'b1;
        prog_en_d      = 1'b0;
        prog_addr_d    = prog_addr_q;
        prog_data_d    = prog_data_q;
        start_d        = start_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            IDLE, RUN, ERR: begin
                // A sync byte only restarts a frame from these idle-like states
                if (accept && is_sync) begin
                    state_d        = LEN0;
                    start_d        = 1'b0;
                    load_done_d    = 1'b0;
                    load_error_d   = 1'b0;
                    words_loaded_d = 16'd0;
                    csum_d         = 8'd0;
                end
            end
            LEN0: begin
                if (accept) begin
                    n_d[7:0] = rx_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    n_d[15:8] = rx_data;
                    if ({1'b0, n_full} > MAX_W) begin
                        state_d      = ERR;
                        load_error_d = 1'b1;
                    end else if (n_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = 16'd0;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            DATA: begin
                // Leave DATA only after the final write strobe has been issued
                if (prog_en_q) begin
                    if (word_idx_q == n_q) begin
                        state_d = CSUM;
                    end
                end else if (accept) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            prog_en_d      = 1'b1;
                            rx_ready_d     = 1'b0;
                            prog_data_d    = {rx_data, asm_q};
                            prog_addr_d    = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            word_idx_d     = word_idx_q + 16'd1;
                            words_loaded_d = words_loaded_q + 16'd1;
                        end
                    endcase
                end
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                        start_d     = 1'b1;
                    end else begin
                        state_d      = ERR;
                        load_error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            n_q            <= 16'd0;
            word_idx_q     <= 16'd0;
            byte_idx_q     <= 2'd0;
            asm_q          <= 24'd0;
            csum_q         <= 8'd0;
            rx_ready_q     <= 1'b0;
            prog_en_q      <= 1'b0;
            prog_addr_q    <= BASE_ADDR;
            prog_data_q    <= 32'd0;
            start_q        <= 1'b0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            word_idx_q     <= word_idx_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            csum_q         <= csum_d;
            rx_ready_q     <= rx_ready_d;
            prog_en_q      <= prog_en_d;
            prog_addr_q    <= prog_addr_d;
            prog_data_q    <= prog_data_d;
            start_q        <= start_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign prog_en      = prog_en_q;
    assign prog_addr    = prog_addr_q;
    assign prog_data    = prog_data_q;
    assign start        = start_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int          MAXW = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wlog[$];
    logic [7:0]  fr[$];
    logic        armed;

    bit          m_done, m_err, m_start, m_oversize;
    int          m_words;
    logic [7:0]  m_csum;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) armed <= 1'b0;
        else     armed <= 1'b1;
    end

    // Every write strobe must match the next write the frame model predicted
    always @(negedge clk) begin
        if (!rst) begin
            if (prog_en) begin
                wlog.push_back({prog_addr, prog_data});
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL unexpected_write: got %0h:%0h expected none", prog_addr, prog_data);
                end else begin
                    chk("write", {prog_addr, prog_data}, exp_q.pop_front());
                end
            end
            if (armed) chk("rx_ready_vs_prog_en", {63'd0, rx_ready}, {63'd0, !prog_en});
            chk("start_and_prog_en", {63'd0, start & prog_en}, 64'd0);
        end
    end

    // Frame-level model: interprets the byte list fr as one frame
    task automatic model_frame();
        int n, nd, used;
        n = int'({fr[2], fr[1]});
        m_done = 0; m_err = 0; m_start = 0; m_words = 0; m_csum = 8'd0;
        m_oversize = (n > MAXW);
        if (m_oversize) begin
            m_err = 1;
            return;
        end
        nd   = fr.size() - 3;
        used = (nd < 4 * n) ? nd : 4 * n;
        for (int i = 0; i < used; i++) m_csum ^= fr[3 + i];
        m_words = used / 4;
        for (int w = 0; w < m_words; w++)
            exp_q.push_back({BASE + 32'(4 * w),
                             fr[3+4*w+3], fr[3+4*w+2], fr[3+4*w+1], fr[3+4*w]});
        if (nd > 4 * n) begin
            if (fr[3 + 4 * n] == m_csum) begin
                m_done = 1;
                m_start = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        cnt = 0;
        while (!rx_ready && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 50) begin
            nchecks++;
            nerrors++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap, input bit check_status);
        model_frame();
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            if (i == 0) begin
                chk("sync_start", {63'd0, start}, 64'd0);
                chk("sync_done", {63'd0, load_done}, 64'd0);
                chk("sync_error", {63'd0, load_error}, 64'd0);
                chk("sync_words", {48'd0, words_loaded}, 64'd0);
            end
            if (i == 2 && m_oversize) chk("oversize_err_now", {63'd0, load_error}, 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        if (check_status) begin
            chk("load_done", {63'd0, load_done}, {63'd0, m_done});
            chk("load_error", {63'd0, load_error}, {63'd0, m_err});
            chk("start", {63'd0, start}, {63'd0, m_start});
            chk("words_loaded", {48'd0, words_loaded}, 64'(m_words));
        end
    endtask

    task automatic chk_reset();
        chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("rst_prog_en", {63'd0, prog_en}, 64'd0);
        chk("rst_prog_addr", {32'd0, prog_addr}, {32'd0, BASE});
        chk("rst_prog_data", {32'd0, prog_data}, 64'd0);
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_done", {63'd0, load_done}, 64'd0);
        chk("rst_error", {63'd0, load_error}, 64'd0);
        chk("rst_words", {48'd0, words_loaded}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        logic [7:0] cs, b;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;

        // Non-sync byte in IDLE is discarded
        send_byte(8'h11, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_discard_start", {63'd0, start}, 64'd0);
        chk("idle_discard_words", {48'd0, words_loaded}, 64'd0);

        // Basic two-word frame
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        nw = wlog.size();
        send_frame(0, 1);
        chk("model_csum_pin", {56'd0, m_csum}, 64'h7C);
        chk("lit_nwrites", 64'(wlog.size() - nw), 64'd2);
        chk("lit_write0", wlog[nw], {32'h0, 32'h0000_0013});
        chk("lit_write1", wlog[nw + 1], {32'h4, 32'h0000_006F});
        chk("lit_done", {63'd0, load_done}, 64'd1);
        chk("lit_start", {63'd0, start}, 64'd1);
        chk("lit_words", {48'd0, words_loaded}, 64'd2);

        // Bad checksum: writes happen, error sticky, start low
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
        send_frame(0, 1);
        chk("lit_bad_err", {63'd0, load_error}, 64'd1);
        chk("lit_bad_start", {63'd0, start}, 64'd0);

        // Recovery from ERR
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        send_frame(0, 1);
        chk("lit_recover_start", {63'd0, start}, 64'd1);

        // Oversize header N=1025
        fr = {8'hA5, 8'h01, 8'h04};
        nw = wlog.size();
        send_frame(0, 1);
        chk("lit_oversize_nowrite", 64'(wlog.size() - nw), 64'd0);
        chk("lit_oversize_err", {63'd0, load_error}, 64'd1);

        // Empty frame
        fr = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0, 1);
        chk("lit_empty_start", {63'd0, start}, 64'd1);
        chk("lit_empty_words", {48'd0, words_loaded}, 64'd0);

        // Reload while running (sync-time checks inside send_frame)
        fr = {8'hA5, 8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
        nw = wlog.size();
        send_frame(0, 1);
        chk("lit_reload_write", wlog[nw], {32'h0, 32'h0000_1237});
        chk("lit_reload_start", {63'd0, start}, 64'd1);

        // Three-word frame with random rx_valid gaps, sync bytes inside payload
        fr = {8'hA5, 8'h03, 8'h00};
        cs = 8'd0;
        for (int i = 0; i < 12; i++) begin
            b = (i == 5) ? 8'hA5 : 8'($urandom);
            fr.push_back(b);
            cs ^= b;
        end
        fr.push_back(cs);
        send_frame(5, 1);

        // Reset after six data bytes of a two-word frame
        fr = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        nw = wlog.size();
        send_frame(3, 0);
        #1;
        rst = 1'b1;
        #1;
        chk_reset();
        chk("lit_rst_nwrites", 64'(wlog.size() - nw), 64'd1);
        chk("lit_rst_write0", wlog[nw], {32'h0, 32'h4433_2211});
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_words", {48'd0, words_loaded}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
